traffic_sensor_filter: RTL and testbench

- Conditions raw vehicle-detector inputs for the two approaches, A and B, before they reach the traffic-light controller.
- Per channel: 2-FF synchronise, debounce, then hold presence for a fixed time after the vehicle leaves (gap-fill).
- The conditioned presence drives the controller's traffic_A/traffic_B inputs directly.
- Also keeps a saturating per-approach vehicle count for monitoring.

---
 rtl/traffic_sensor_filter.sv | 123 ++++++++++++
 tb/tb_traffic_sensor_filter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_filter.sv
// Vehicle-detector conditioning for approaches A and B: synchronise, debounce, gap-fill
// presence, and keep saturating arrival counts for monitoring.
module traffic_sensor_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_A,
  input  logic               raw_B,
  input  logic               clr_counts,
  output logic               traffic_A,
  output logic               traffic_B,
  output logic               arrive_A,
  output logic               arrive_B,
  output logic [COUNT_W-1:0] count_A,
  output logic [COUNT_W-1:0] count_B
);

  typedef enum logic [1:0] {StIdle, StPresent, StHold} state_e;

  localparam logic [7:0]         DebLast  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         HoldLoad = 8'(HOLD_CYCLES);
  localparam logic [COUNT_W-1:0] CountMax = '1;
  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

  // Channel index 0 is approach A, 1 is approach B.
  logic [1:0]         raw;
  logic [1:0]         sync1_q;
  logic [1:0]         sync2_q;
  logic [1:0]         deb_q;
  logic [1:0]         traffic_q;
  logic [1:0]         arrive_q;
  logic [7:0]         deb_cnt_q  [2];
  logic [7:0]         hold_cnt_q [2];
  state_e             state_q    [2];
  logic [COUNT_W-1:0] count_q    [2];

  assign raw = {raw_B, raw_A};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      traffic_q <= '0;
      arrive_q  <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        deb_cnt_q[ch]  <= '0;
        hold_cnt_q[ch] <= '0;
        state_q[ch]    <= StIdle;
        count_q[ch]    <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int ch = 0; ch < 2; ch++) begin
        // Debounce: a differing level must persist DEBOUNCE_CYCLES cycles to be accepted.
        if (sync2_q[ch] == deb_q[ch]) begin
          deb_cnt_q[ch] <= '0;
        end else if (deb_cnt_q[ch] == DebLast) begin
          deb_q[ch]     <= ~deb_q[ch];
          deb_cnt_q[ch] <= '0;
        end else begin
          deb_cnt_q[ch] <= deb_cnt_q[ch] + 8'd1;
        end

        // deb_q can only be high outside StPresent on the cycle right after it rose.
        arrive_q[ch] <= deb_q[ch] && (state_q[ch] != StPresent);

        unique case (state_q[ch])
          StIdle: begin
            if (deb_q[ch]) begin
              state_q[ch]   <= StPresent;
              traffic_q[ch] <= 1'b1;
            end
          end
          StPresent: begin
            if (!deb_q[ch]) begin
              if (HOLD_CYCLES == 0) begin
                state_q[ch]   <= StIdle;
                traffic_q[ch] <= 1'b0;
              end else begin
                state_q[ch]    <= StHold;
                hold_cnt_q[ch] <= HoldLoad;
              end
            end
          end
          StHold: begin
            if (deb_q[ch]) begin
              state_q[ch] <= StPresent;
            end else if (hold_cnt_q[ch] == 8'd1) begin
              state_q[ch]    <= StIdle;
              traffic_q[ch]  <= 1'b0;
              hold_cnt_q[ch] <= '0;
            end else begin
              hold_cnt_q[ch] <= hold_cnt_q[ch] - 8'd1;
            end
          end
          default: begin
            state_q[ch]   <= StIdle;
            traffic_q[ch] <= 1'b0;
          end
        endcase

        if (clr_counts) begin
          count_q[ch] <= '0;
        end else if (arrive_q[ch] && (count_q[ch] != CountMax)) begin
          count_q[ch] <= count_q[ch] + CountOne;
        end
      end
    end
  end

  assign traffic_A = traffic_q[0];
  assign traffic_B = traffic_q[1];
  assign arrive_A  = arrive_q[0];
  assign arrive_B  = arrive_q[1];
  assign count_A   = count_q[0];
  assign count_B   = count_q[1];

endmodule

// File: tb/tb_traffic_sensor_filter.sv
// Directed bench for traffic_sensor_filter: vector table for reset/latency/glitch/independence,
// plus sequences for hold re-arrival, saturation, coincident clear and mid-operation reset.
module tb_traffic_sensor_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_A;
  logic       raw_B;
  logic       clr_counts;
  logic       traffic_A;
  logic       traffic_B;
  logic       arrive_A;
  logic       arrive_B;
  logic [7:0] count_A;
  logic [7:0] count_B;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       ra;
    logic       rb;
    logic       clr;
    logic       exp_ta;
    logic       exp_tb;
    logic       exp_aa;
    logic       exp_ab;
    logic [7:0] exp_ca;
    logic [7:0] exp_cb;
  } vec_t;

  vec_t vecs[$];

  traffic_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .COUNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_A     (raw_A),
    .raw_B     (raw_B),
    .clr_counts(clr_counts),
    .traffic_A (traffic_A),
    .traffic_B (traffic_B),
    .arrive_A  (arrive_A),
    .arrive_B  (arrive_B),
    .count_A   (count_A),
    .count_B   (count_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, then look 1 time unit after that edge.
  task automatic cyc(input logic rst, input logic ra, input logic rb, input logic clr);
    reset      = rst;
    raw_A      = ra;
    raw_B      = rb;
    clr_counts = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic ra, input logic rb, input logic clr,
                     input logic ta, input logic tb, input logic aa, input logic ab,
                     input int ca, input int cb);
    vec_t v;
    v.rst    = rst;
    v.ra     = ra;
    v.rb     = rb;
    v.clr    = clr;
    v.exp_ta = ta;
    v.exp_tb = tb;
    v.exp_aa = aa;
    v.exp_ab = ab;
    v.exp_ca = 8'(ca);
    v.exp_cb = 8'(cb);
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   arr;
    int   seen;
    int   pulses;
    logic dropped;
    logic rose;

    reset      = 1'b1;
    raw_A      = 1'b0;
    raw_B      = 1'b0;
    clr_counts = 1'b0;

    // Reset held with both detectors active: everything stays 0.
    for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Release: first sample k=0, presence/arrival at k=6, count follows at k=7.
    for (int k = 0; k < 12; k++)
      add(0, 1, 1, 0, k >= 6, k >= 6, k == 6, k == 6, (k >= 7) ? 1 : 0, (k >= 7) ? 1 : 0);
    // A leaves (first low sample k=0): traffic_A drops at k=14; B untouched.
    for (int k = 0; k < 16; k++) add(0, 0, 1, 0, k < 14, 1, 0, 0, 1, 1);
    // 3-cycle glitch on A is rejected.
    for (int k = 0; k < 11; k++) add(0, k < 3, 1, 0, 0, 1, 0, 0, 1, 1);
    // 4-cycle pulse on A is accepted while B leaves at the same time.
    for (int k = 0; k < 20; k++)
      add(0, k < 4, 0, 0, (k >= 6) && (k < 18), k < 14, k == 6, 0, (k >= 7) ? 2 : 1, 1);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].clr);
      chk($sformatf("v%0d traffic_A", i), traffic_A, vecs[i].exp_ta);
      chk($sformatf("v%0d traffic_B", i), traffic_B, vecs[i].exp_tb);
      chk($sformatf("v%0d arrive_A", i), arrive_A, vecs[i].exp_aa);
      chk($sformatf("v%0d arrive_B", i), arrive_B, vecs[i].exp_ab);
      chk($sformatf("v%0d count_A", i), count_A, vecs[i].exp_ca);
      chk($sformatf("v%0d count_B", i), count_B, vecs[i].exp_cb);
    end

    // Hold and re-arrival: A re-raised 5 cycles after leaving, presence never drops.
    arr     = 0;
    dropped = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 0, 0);
      if (arrive_A) arr++;
      if (k >= 6 && !traffic_A) dropped = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      if (arrive_A) arr++;
      if (!traffic_A) dropped = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 0, 0);
      if (arrive_A) arr++;
      if (!traffic_A) dropped = 1'b1;
    end
    chk("rearrive traffic_A dropped", dropped, 0);
    chk("rearrive arrive_A pulses", arr, 2);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("hold fall k%0d traffic_A", k), traffic_A, k < 14);
    end
    chk("rearrive count_A", count_A, 4);

    // Saturation: 260 clean B pulses from count 1 must stop at 255, not wrap.
    pulses = 0;
    for (int p = 0; p < 260; p++) begin
      for (int k = 0; k < 10; k++) begin
        cyc(0, 0, 1, 0);
        if (arrive_B) pulses++;
      end
      for (int k = 0; k < 20; k++) begin
        cyc(0, 0, 0, 0);
        if (arrive_B) pulses++;
      end
    end
    chk("sat arrive_B pulses", pulses, 260);
    chk("sat count_B", count_B, 255);
    chk("sat count_A", count_A, 4);

    // Clear coincident with an arrive_B pulse: clear wins, arrival not counted.
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      cyc(0, 0, 1, 0);
      if (arrive_B) seen = 1;
    end
    chk("clr arrive_B seen", seen, 1);
    chk("clr count_B before", count_B, 255);
    cyc(0, 0, 1, 1);
    chk("clr count_B", count_B, 0);
    chk("clr count_A", count_A, 0);
    cyc(0, 0, 1, 0);
    chk("clr count_B after", count_B, 0);
    for (int k = 0; k < 30; k++) cyc(0, 0, 0, 0);

    // Mid-operation reset: bring count_A to 7, enter HOLD, then reset.
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0);
      for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0);
    end
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0);
    chk("midrst traffic_A in hold", traffic_A, 1);
    chk("midrst count_A before", count_A, 7);
    cyc(1, 0, 0, 0);
    chk("midrst traffic_A", traffic_A, 0);
    chk("midrst count_A", count_A, 0);
    chk("midrst arrive_A", arrive_A, 0);
    rose = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0);
      if (traffic_A || arrive_A) rose = 1'b1;
    end
    chk("midrst traffic_A after release", rose, 0);
    chk("midrst count_A after release", count_A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
